// File: rtl/bmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bmem_burst_arbiter
// Brief    : Round-robin N-port arbiter that multiplexes cache burst
//            requesters onto the single bmem burst interface.
// Revision : 1.0 - initial release
// ============================================================================
module bmem_burst_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_PORTS-1:0]        port_read,
    input  logic [NUM_PORTS-1:0]        port_write,
    input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]        port_wack,
    output logic [DATA_W-1:0]           port_rdata,
    output logic [NUM_PORTS-1:0]        port_rvalid,
    output logic [NUM_PORTS-1:0]        port_done,
    output logic [NUM_PORTS-1:0]        port_grant,
    output logic [ADDR_W-1:0]           bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [DATA_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [ADDR_W-1:0]           bmem_raddr,
    input  logic [DATA_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid,
    output logic                        err_stray_rvalid
);

    localparam int c_IDX_W  = $clog2(NUM_PORTS);
    localparam int c_BEAT_W = $clog2(BURST_LEN);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_CMD  = 2'd1;
    localparam logic [1:0] c_ST_RD_DATA = 2'd2;
    localparam logic [1:0] c_ST_WR_DATA = 2'd3;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   r_grant_idx;
    logic [c_IDX_W-1:0]   w_win_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_win_found;
    logic [NUM_PORTS-1:0] r_grant;
    logic [NUM_PORTS-1:0] w_req;
    logic [c_BEAT_W-1:0]  r_beat;
    logic                 r_err_stray;
    logic                 w_rd_beat;
    logic                 w_wr_beat;
    logic                 w_last;
    logic                 w_unused_raddr;

    logic [ADDR_W-1:0] w_addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0] w_wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = port_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = port_wdata[g*DATA_W +: DATA_W];
    end

    // Returning read addresses are deliberately not cross-checked.
    assign w_unused_raddr = ^bmem_raddr;

    assign w_req     = port_read | port_write;
    assign w_rd_beat = (r_state == c_ST_RD_DATA) && bmem_rvalid;
    assign w_wr_beat = (r_state == c_ST_WR_DATA) && bmem_ready;
    assign w_last    = (r_beat == c_LAST_BEAT);

    // Scan starts just after the previous owner, so the previous owner has lowest priority.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = c_IDX_W'((int'(r_last_grant) + k) % NUM_PORTS);
            if (!w_win_found && w_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = port_write[w_win_idx] ? c_ST_WR_DATA : c_ST_RD_CMD;
                end
            end
            c_ST_RD_CMD: begin
                if (bmem_ready) begin
                    w_state_nxt = c_ST_RD_DATA;
                end
            end
            c_ST_RD_DATA: begin
                if (w_rd_beat && w_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WR_DATA: begin
                if (w_wr_beat && w_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_IDX_W'(NUM_PORTS - 1);
            r_grant_idx  <= '0;
            r_grant      <= '0;
            r_beat       <= '0;
            r_err_stray  <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && w_win_found) begin
                r_grant_idx  <= w_win_idx;
                r_last_grant <= w_win_idx;
                r_grant      <= NUM_PORTS'(1) << w_win_idx;
            end else if (r_state != c_ST_IDLE && w_state_nxt == c_ST_IDLE) begin
                r_grant <= '0;
            end

            // Power-of-two burst length lets the counter wrap to 0 on the last beat.
            if (r_state == c_ST_IDLE) begin
                r_beat <= '0;
            end else if (w_rd_beat || w_wr_beat) begin
                r_beat <= r_beat + 1'b1;
            end

            if (bmem_rvalid && r_state != c_ST_RD_DATA) begin
                r_err_stray <= 1'b1;
            end
        end
    end

    assign port_grant       = r_grant;
    assign bmem_read        = (r_state == c_ST_RD_CMD);
    assign bmem_write       = (r_state == c_ST_WR_DATA);
    assign bmem_addr        = (r_state != c_ST_IDLE) ? w_addr_arr[r_grant_idx] : '0;
    assign bmem_wdata       = bmem_write ? w_wdata_arr[r_grant_idx] : '0;
    assign port_rdata       = w_rd_beat ? bmem_rdata : '0;
    assign port_rvalid      = w_rd_beat ? r_grant : '0;
    assign port_wack        = w_wr_beat ? r_grant : '0;
    assign port_done        = ((w_rd_beat || w_wr_beat) && w_last) ? r_grant : '0;
    assign err_stray_rvalid = r_err_stray;

`ifndef SYNTHESIS
    // The owning port must keep its request up until its burst completes.
    a_grant_held : assert property (@(posedge clk) disable iff (rst)
        (r_state != c_ST_IDLE) |-> |(w_req & r_grant));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmem_burst_arbiter
// Brief    : Randomised scoreboard bench for bmem_burst_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmem_burst_arbiter;

    localparam int NP       = 3;
    localparam int AW       = 32;
    localparam int DW       = 64;
    localparam int BL       = 4;
    localparam int N_BURSTS = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*AW-1:0] port_addr;
    logic [NP-1:0]   port_read;
    logic [NP-1:0]   port_write;
    logic [NP*DW-1:0] port_wdata;
    logic [NP-1:0]   port_wack;
    logic [DW-1:0]   port_rdata;
    logic [NP-1:0]   port_rvalid;
    logic [NP-1:0]   port_done;
    logic [NP-1:0]   port_grant;
    logic [AW-1:0]   bmem_addr;
    logic            bmem_read;
    logic            bmem_write;
    logic [DW-1:0]   bmem_wdata;
    logic            bmem_ready;
    logic [AW-1:0]   bmem_raddr;
    logic [DW-1:0]   bmem_rdata;
    logic            bmem_rvalid;
    logic            err_stray_rvalid;

    always #5 clk = ~clk;

    bmem_burst_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .port_addr        (port_addr),
        .port_read        (port_read),
        .port_write       (port_write),
        .port_wdata       (port_wdata),
        .port_wack        (port_wack),
        .port_rdata       (port_rdata),
        .port_rvalid      (port_rvalid),
        .port_done        (port_done),
        .port_grant       (port_grant),
        .bmem_addr        (bmem_addr),
        .bmem_read        (bmem_read),
        .bmem_write       (bmem_write),
        .bmem_wdata       (bmem_wdata),
        .bmem_ready       (bmem_ready),
        .bmem_raddr       (bmem_raddr),
        .bmem_rdata       (bmem_rdata),
        .bmem_rvalid      (bmem_rvalid),
        .err_stray_rvalid (err_stray_rvalid)
    );

    typedef struct {
        bit            is_cmd;
        logic [NP-1:0] grant;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [NP-1:0] rv;
        logic [NP-1:0] wk;
        logic [NP-1:0] dn;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_err  = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: first requester after the previous owner.
    function automatic int rr_pick(input logic [NP-1:0] req, input int last);
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (last + k) % NP;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    // Monitor: pops one expected event per command start and per beat/done cycle.
    logic [NP-1:0] mon_prev_grant = '0;
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (port_grant != '0 && mon_prev_grant == '0) begin
                if (exp_q.size() == 0 || !exp_q[0].is_cmd) begin
                    check("cmd_unexpected", port_grant, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_grant", port_grant, e.grant);
                    check("cmd_read", bmem_read, e.rd);
                    check("cmd_write", bmem_write, e.wr);
                    check("cmd_addr", bmem_addr, e.addr);
                end
            end
            if ((port_rvalid | port_wack | port_done) != '0) begin
                if (exp_q.size() == 0 || exp_q[0].is_cmd) begin
                    check("beat_unexpected", {port_rvalid, port_wack, port_done}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_rvalid", port_rvalid, e.rv);
                    check("beat_wack", port_wack, e.wk);
                    check("beat_done", port_done, e.dn);
                    if (e.rv != '0) check("beat_rdata", port_rdata, e.data);
                    else            check("beat_wdata", bmem_wdata, e.data);
                end
            end
            mon_prev_grant = port_grant;
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero();
        check("rst_ctrl", {port_grant, port_rvalid, port_wack, port_done,
                           bmem_read, bmem_write, err_stray_rvalid}, '0);
        check("rst_bus", {bmem_addr, bmem_wdata}, '0);
        check("rst_rdata", port_rdata, '0);
    endtask

    initial begin
        int            last_g, w, op, k, stall, fb;
        bit            is_wr, rdy, rst_done, after_rst, aborted, err_exp;
        logic [DW-1:0] wbase;
        ev_t           e;

        rst = 1'b1; port_addr = '0; port_read = '0; port_write = '0; port_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        rst_done = 1'b0; after_rst = 1'b0; err_exp = 1'b0; last_g = NP - 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_all_zero();

        // Stray read beat while idle: ignored, but sets the sticky flag.
        @(posedge clk); #1;
        bmem_rvalid = 1'b1;
        bmem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        check("stray_rvalid", port_rvalid, '0);
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
        err_exp     = 1'b1;
        @(negedge clk);
        check("err_set", err_stray_rvalid, 1'b1);
        @(posedge clk); #1;

        for (int b = 0; b < N_BURSTS; b++) begin
            bmem_ready = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!(port_read[p] | port_write[p]) &&
                    ($urandom_range(0, 1) == 1 || (after_rst && p == 0))) begin
                    op = (b >= N_BURSTS / 2 && !rst_done) ? 0 : int'($urandom_range(0, 2));
                    port_read[p]  = (op != 1);
                    port_write[p] = (op != 0);
                    port_addr[p*AW +: AW]  = $urandom & ~32'h3f;
                    port_wdata[p*DW +: DW] = {$urandom, $urandom};
                end
            end
            if ((port_read | port_write) == '0) begin
                fb = int'($urandom_range(0, NP - 1));
                port_read[fb] = 1'b1;
                port_addr[fb*AW +: AW] = $urandom & ~32'h3f;
            end
            after_rst = 1'b0;

            w      = rr_pick(port_read | port_write, last_g);
            last_g = w;
            is_wr  = port_write[w];
            e = '{default: '0};
            e.is_cmd = 1'b1;
            e.grant  = NP'(1) << w;
            e.rd     = !is_wr;
            e.wr     = is_wr;
            e.addr   = port_addr[w*AW +: AW];
            exp_q.push_back(e);
            wbase = {$urandom, $urandom};
            if (is_wr) port_wdata[w*DW +: DW] = wbase;

            @(negedge clk);
            check("idle_grant", port_grant, '0);
            check("err_flag", err_stray_rvalid, err_exp);
            @(posedge clk); #1;

            aborted = 1'b0;
            if (!is_wr) begin
                stall = 0;
                do begin
                    rdy = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                    bmem_ready = rdy;
                    stall++;
                    @(negedge clk);
                    @(posedge clk); #1;
                end while (!rdy);
                bmem_ready = 1'b0;
                for (k = 0; k < BL; k++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        bmem_rvalid = 1'b0;
                        @(negedge clk);
                        @(posedge clk); #1;
                    end
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = {$urandom, $urandom};
                    bmem_raddr  = $urandom;
                    e = '{default: '0};
                    e.rv   = NP'(1) << w;
                    e.dn   = (k == BL - 1) ? (NP'(1) << w) : '0;
                    e.data = bmem_rdata;
                    exp_q.push_back(e);
                    @(negedge clk);
                    check("rd_cmd_dropped", bmem_read, 1'b0);
                    @(posedge clk); #1;
                    if (!rst_done && b >= N_BURSTS / 2 && k == 1) begin
                        bmem_rvalid = 1'b0;
                        rst = 1'b1;
                        port_read = '0;
                        port_write = '0;
                        @(negedge clk);
                        @(posedge clk); #1;
                        rst = 1'b0;
                        @(negedge clk);
                        check_all_zero();
                        last_g = NP - 1;
                        err_exp = 1'b0;
                        rst_done = 1'b1;
                        after_rst = 1'b1;
                        aborted = 1'b1;
                        @(posedge clk); #1;
                        break;
                    end
                end
                bmem_rvalid = 1'b0;
            end else begin
                k = 0;
                stall = 0;
                while (k < BL) begin
                    rdy = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                    bmem_ready = rdy;
                    if (rdy) begin
                        e = '{default: '0};
                        e.wk   = NP'(1) << w;
                        e.dn   = (k == BL - 1) ? (NP'(1) << w) : '0;
                        e.data = wbase + DW'(k);
                        exp_q.push_back(e);
                    end
                    @(negedge clk);
                    if (!rdy) check("wdata_hold", bmem_wdata, wbase + DW'(k));
                    @(posedge clk); #1;
                    if (rdy) begin
                        k++;
                        stall = 0;
                        port_wdata[w*DW +: DW] = wbase + DW'(k);
                    end else begin
                        stall++;
                    end
                end
                bmem_ready = 1'b0;
            end
            if (!aborted) begin
                port_read[w]  = 1'b0;
                port_write[w] = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_idle", port_grant, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmem_burst_arbiter.md
Name: bmem_burst_arbiter

Overview:
- Parametrised N-port arbiter that multiplexes cache-side burst requesters (instruction/data caches of the OoO and pipelined cores, plus any added requesters) onto the single bmem burst interface feeding fpga_mem_controller.
- Successor to the fixed two-core sharing logic: adds fair round-robin arbitration, configurable port count and burst length, write-beat backpressure, per-port completion pulses and stray-response detection.

Parameters:
- NUM_PORTS, 2, number of requesting ports (≥2).
- ADDR_W, 32, byte-address width.
- DATA_W, 64, beat width.
- BURST_LEN, 4, beats per burst (power of two, ≥2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- port_addr  input  NUM_PORTS*ADDR_W  per-port burst base address; slice i belongs to port i.
- port_read  input  NUM_PORTS  per-port read request; held until port_done.
- port_write  input  NUM_PORTS  per-port write request; held until port_done.
- port_wdata  input  NUM_PORTS*DATA_W  current write beat; the port advances it after each port_wack.
- port_wack  output  NUM_PORTS  one-hot pulse: current write beat consumed.
- port_rdata  output  DATA_W  read beat, shared by all ports.
- port_rvalid  output  NUM_PORTS  one-hot pulse: port_rdata valid for that port.
- port_done  output  NUM_PORTS  one-hot pulse on the final beat of a granted burst.
- port_grant  output  NUM_PORTS  one-hot current owner; all zero in IDLE.
- bmem_addr  output  ADDR_W  burst address.
- bmem_read  output  1  read command.
- bmem_write  output  1  write beat valid.
- bmem_wdata  output  DATA_W  write beat.
- bmem_ready  input  1  controller accepts command or beat this cycle.
- bmem_raddr  input  ADDR_W  address of the returning read burst.
- bmem_rdata  input  DATA_W  read beat.
- bmem_rvalid  input  1  read beat valid.
- err_stray_rvalid  output  1  sticky flag; cleared only by rst.

Behaviour:
- Single clock domain: clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, last_grant = NUM_PORTS-1 (so port 0 wins first), beat counter 0, all outputs 0, err_stray_rvalid 0. An rst asserted mid-burst abandons the burst immediately: no port_done is issued and bmem_read/bmem_write drop in the next cycle.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA.
- IDLE:
  - req[i] = port_read[i] | port_write[i].
  - Winner is the first requesting port scanning last_grant+1, last_grant+2, … modulo NUM_PORTS.
  - Winner is registered into port_grant and last_grant; the state moves to WR_DATA if port_write[winner], else RD_CMD.
  - If both read and write are asserted on the winning port, write wins.
  - No request: stay in IDLE.
  - Latency: bmem command is visible 1 cycle after the request is first seen in IDLE.
- RD_CMD:
  - bmem_read=1; bmem_addr = granted port_addr.
  - Hold until bmem_ready=1, then go to RD_DATA with beat count 0.
- RD_DATA:
  - bmem_read=0.
  - Each bmem_rvalid: port_rdata = bmem_rdata (combinational pass-through); port_rvalid pulses for the granted port; count increments.
  - On beat BURST_LEN-1: port_done pulses in the same cycle, then IDLE.
  - bmem_raddr is not checked.
- WR_DATA:
  - bmem_write=1; bmem_addr = granted port_addr; bmem_wdata = granted port_wdata.
  - Each cycle with bmem_ready=1 completes a beat: port_wack pulses, count increments.
  - bmem_ready=0 holds the beat with no wack.
  - On the last beat: port_done pulses together with port_wack, then IDLE. The bmem_write deassertion is registered, so it lands the cycle after the last accepted beat.
- Beat counter: width $clog2(BURST_LEN); wraps to 0 at burst end.
- bmem_rvalid outside RD_DATA: beat is ignored (no port_rvalid) and err_stray_rvalid is set.
- Requests arriving during a burst wait. Deassertion of a request mid-burst by a non-granted port is legal; by the granted port it is illegal (assertion fires in simulation).
- Exactly one outstanding burst at any time. No back-to-back issue without passing through IDLE: 1 idle cycle between bursts.

Test Plan:
- NUM_PORTS=2, port0 read 0x0000_1000, bmem_ready=1, four rvalid beats 0xA0..0xA3 -> bmem_read high 1 cycle after request; port_rvalid[0] ×4 carrying 0xA0..0xA3; port_done[0] on the 4th beat; port_grant returns to 0.
- Ports 0 and 1 both request reads continuously -> grants alternate 0,1,0,1; no port is starved over 8 bursts.
- Port1 write 0x0000_2040 with bmem_ready pattern 1,0,1,1,0,1 -> exactly 4 port_wack[1]; bmem_wdata holds during ready=0; port_done[1] on the 4th accepted beat.
- rst asserted after the 2nd read beat -> next cycle all outputs 0, state IDLE, no port_done; a fresh request is served with port 0 priority.
- bmem_rvalid pulsed while IDLE -> no port_rvalid; err_stray_rvalid=1 and remains set until rst.
- NUM_PORTS=3, BURST_LEN=8, ports 0 and 2 request, port 1 idle -> grant sequence 0,2,0,2; 8 beats each; port 1 never granted.
